// File: rtl/fp_add_frontend.sv
// fp_add_frontend
//   Front end of an IEEE-754 single-precision adder: three registered stages
//   (mask, align, ALU) producing the unnormalized sum/difference of A and B
//   together with the exponent and sign of the larger-magnitude operand.
//   One operand pair is accepted every cycle. There is no backpressure.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset (clears valid bits and outputs)
//   in_valid    a/b carry an operand pair this cycle
//   a, b        IEEE-754 single operands
//   out_valid   in_valid delayed by exactly 3 cycles
//   out_sign    sign of the larger-magnitude operand (0 for an exact-zero difference)
//   out_exp     effective exponent of the larger-magnitude operand
//   out_mant    [27] carry, [26:3] integer+fraction, [2:0] guard/round/sticky
//   out_special either input has exponent 0xFF (NaN/Inf)
module fp_add_frontend (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic        out_sign,
    output logic [7:0]  out_exp,
    output logic [27:0] out_mant,
    output logic        out_special
);

    // ---------------- mask stage ----------------
    logic [7:0]  rawExpA, rawExpB;
    logic [7:0]  effExpA, effExpB;
    logic [23:0] mantA, mantB;
    logic        specialIn;

    always_comb begin
        rawExpA   = a[30:23];
        rawExpB   = b[30:23];
        // Denormals use exponent 1 with a clear hidden bit.
        effExpA   = (rawExpA == 8'd0) ? 8'd1 : rawExpA;
        effExpB   = (rawExpB == 8'd0) ? 8'd1 : rawExpB;
        mantA     = {(rawExpA != 8'd0), a[22:0]};
        mantB     = {(rawExpB != 8'd0), b[22:0]};
        specialIn = (rawExpA == 8'hFF) | (rawExpB == 8'hFF);
    end

    logic        s1Valid;
    logic        s1SignA, s1SignB;
    logic [7:0]  s1ExpA, s1ExpB;
    logic [23:0] s1MantA, s1MantB;
    logic        s1Special;

    always_ff @(posedge clk) begin
        s1SignA   <= a[31];
        s1SignB   <= b[31];
        s1ExpA    <= effExpA;
        s1ExpB    <= effExpB;
        s1MantA   <= mantA;
        s1MantB   <= mantB;
        s1Special <= specialIn;
    end

    // ---------------- align stage ----------------
    logic        aIsLarger;
    logic [7:0]  expL, expS, diff;
    logic [23:0] mantL, mantS;
    logic        signL;
    logic [26:0] mantS27, shifted, lostMask, alignedS;
    logic [4:0]  shAmt;
    logic        sticky;

    always_comb begin
        // Tie goes to A.
        aIsLarger = {s1ExpA, s1MantA} >= {s1ExpB, s1MantB};
        expL      = aIsLarger ? s1ExpA  : s1ExpB;
        expS      = aIsLarger ? s1ExpB  : s1ExpA;
        mantL     = aIsLarger ? s1MantA : s1MantB;
        mantS     = aIsLarger ? s1MantB : s1MantA;
        signL     = aIsLarger ? s1SignA : s1SignB;
        diff      = expL - expS;
        mantS27   = {mantS, 3'b000};
        shAmt     = diff[4:0];
        shifted   = '0;
        lostMask  = '0;
        sticky    = 1'b0;
        if (diff >= 8'd27) begin
            alignedS = {26'd0, (mantS != 24'd0)};
        end else begin
            shifted  = mantS27 >> shAmt;
            lostMask = (27'd1 << shAmt) - 27'd1;
            // Everything shifted out collapses into bit 0.
            sticky   = |(mantS27 & lostMask);
            alignedS = {shifted[26:1], shifted[0] | sticky};
        end
    end

    logic        s2Valid;
    logic [26:0] s2MantL, s2MantS;
    logic [7:0]  s2Exp;
    logic        s2SignL, s2EffSub, s2Special;

    always_ff @(posedge clk) begin
        s2MantL   <= {mantL, 3'b000};
        s2MantS   <= alignedS;
        s2Exp     <= expL;
        s2SignL   <= signL;
        s2EffSub  <= s1SignA ^ s1SignB;
        s2Special <= s1Special;
    end

    // ---------------- ALU stage ----------------
    logic [27:0] aluMant;
    logic        aluSign;

    always_comb begin
        // L >= S by construction, so the difference is never negative.
        aluMant = s2EffSub ? ({1'b0, s2MantL} - {1'b0, s2MantS})
                           : ({1'b0, s2MantL} + {1'b0, s2MantS});
        aluSign = s2SignL & ~(s2EffSub & (aluMant == 28'd0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid   <= 1'b0;
            s2Valid   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            s1Valid   <= in_valid;
            s2Valid   <= s1Valid;
            out_valid <= s2Valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sign    <= 1'b0;
            out_exp     <= '0;
            out_mant    <= '0;
            out_special <= 1'b0;
        end else if (s2Valid) begin
            out_sign    <= aluSign;
            out_exp     <= s2Exp;
            out_mant    <= aluMant;
            out_special <= s2Special;
        end
    end

endmodule

// File: tb/tb_fp_add_frontend.sv
module tb_fp_add_frontend;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a, b;
    logic        out_valid, out_sign, out_special;
    logic [7:0]  out_exp;
    logic [27:0] out_mant;

    fp_add_frontend dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_sign   (out_sign),
        .out_exp    (out_exp),
        .out_mant   (out_mant),
        .out_special(out_special)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] mant;
        logic [7:0]  exp;
        logic        sign;
        logic        special;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int unsigned cycle = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // Reference: magnitude compare, align by integer division with remainder
    // as sticky, then plain add/subtract.
    function automatic exp_t refModel(input logic [31:0] x, input logic [31:0] y);
        exp_t r;
        longint unsigned eA, eB, mA, mB, eL, eS, mL, mS, diff, lx, sx, al, res, p;
        bit sA, sB, sL, aBig;
        sA = x[31];
        sB = y[31];
        eA = (x[30:23] == 8'd0) ? 64'd1 : 64'(x[30:23]);
        eB = (y[30:23] == 8'd0) ? 64'd1 : 64'(y[30:23]);
        mA = ((x[30:23] != 8'd0) ? 64'd8388608 : 64'd0) + 64'(x[22:0]);
        mB = ((y[30:23] != 8'd0) ? 64'd8388608 : 64'd0) + 64'(y[22:0]);
        aBig = (eA * 64'd16777216 + mA) >= (eB * 64'd16777216 + mB);
        eL = aBig ? eA : eB;  eS = aBig ? eB : eA;
        mL = aBig ? mA : mB;  mS = aBig ? mB : mA;
        sL = aBig ? sA : sB;
        diff = eL - eS;
        lx = mL * 8;
        sx = mS * 8;
        if (diff >= 27) begin
            al = (mS != 0) ? 64'd1 : 64'd0;
        end else begin
            p  = 64'd1 << diff;
            al = sx / p;
            if (sx % p != 0) al = al | 64'd1;
        end
        res = (sA == sB) ? lx + al : lx - al;
        r.mant    = res[27:0];
        r.exp     = eL[7:0];
        r.sign    = (sA != sB && res == 0) ? 1'b0 : sL;
        r.special = (x[30:23] == 8'hFF) || (y[30:23] == 8'hFF);
        r.due     = 0;
        return r;
    endfunction

    // Monitor: reset-state check while in reset, scoreboard pop on out_valid.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            checks++;
            if (out_valid !== 1'b0 || out_sign !== 1'b0 || out_exp !== 8'd0 ||
                out_mant !== 28'd0 || out_special !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: valid=%b sign=%b exp=%h mant=%h special=%b, required all 0",
                         out_valid, out_sign, out_exp, out_mant, out_special);
            end
        end else if (out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_valid: out_valid=1 at cycle %0d, required 0 (nothing in flight)", cycle);
            end else begin
                e = sb.pop_front();
                if (out_mant !== e.mant || out_exp !== e.exp || out_sign !== e.sign ||
                    out_special !== e.special || cycle != e.due) begin
                    errors++;
                    $display("FAIL result: got mant=%h exp=%h sign=%b special=%b cycle=%0d, required mant=%h exp=%h sign=%b special=%b cycle=%0d",
                             out_mant, out_exp, out_sign, out_special, cycle,
                             e.mant, e.exp, e.sign, e.special, e.due);
                end
            end
        end
    end

    task automatic pushExp(input exp_t e);
        exp_t t;
        t = e;
        t.due = cycle + 3;
        sb.push_back(t);
    endtask

    task automatic issue(input logic [31:0] x, input logic [31:0] y);
        in_valid = 1'b1; a = x; b = y;
        pushExp(refModel(x, y));
        @(posedge clk); #1;
    endtask

    task automatic issueConst(input logic [31:0] x, input logic [31:0] y,
                              input logic [27:0] m, input logic [7:0] ex, input logic s);
        exp_t e;
        in_valid = 1'b1; a = x; b = y;
        e.mant = m; e.exp = ex; e.sign = s; e.special = 1'b0; e.due = 0;
        pushExp(e);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; a = $urandom; b = $urandom;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] randOperand(input logic [7:0] nearExp);
        logic [7:0]  e;
        int unsigned k;
        k = $urandom_range(0, 9);
        if (k == 0)      e = 8'h00;
        else if (k == 1) e = 8'hFF;
        else if (k < 6)  e = nearExp + 8'($urandom_range(0, 6)) - 8'd3;
        else             e = 8'($urandom);
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    initial begin
        logic [31:0] x, y;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed: known results.
        issueConst(32'h3F800000, 32'h3F800000, 28'h8000000, 8'h7F, 1'b0);
        issueConst(32'h3F800000, 32'hBF800000, 28'h0000000, 8'h7F, 1'b0);
        issueConst(32'h3F800000, 32'h30800000, 28'h4000001, 8'h7F, 1'b0);
        issue(32'hBF9F5C29, 32'h40303127);   // about -1.245 + 2.753
        issue(32'h7FC00000, 32'h12345678);   // NaN operand
        issue(32'h00000001, 32'h80000003);   // denormals, effective subtraction
        idle();

        // Back-to-back pairs with a reset pulse after the second one.
        issue(32'h40000000, 32'h3F000000);
        issue(32'hC0400000, 32'h3E800000);
        rst_n = 1'b0;
        sb.delete();
        in_valid = 1'b1; a = 32'h3F800000; b = 32'h3F800000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(32'h41200000, 32'hC0A00000);
        issue(32'h3F800001, 32'hBF800000);
        issue(32'h7F800000, 32'hFF800000);
        idle();

        // Randomized stream with gaps.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                x = randOperand(8'h80);
                case ($urandom_range(0, 5))
                    0:       y = {~x[31], x[30:0]};
                    1:       y = x;
                    default: y = randOperand(x[30:23]);
                endcase
                if ($urandom_range(0, 1) == 1) issue(x, y);
                else                           issue(y, x);
            end
        end
        in_valid = 1'b0;

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
